uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serial UART transmitter (8N1 by default) clocked from the board clock.
//   Consumes the divided rate as an internal bit-period tick rather than a
//   derived clock.
//   Sits downstream of the power-on reset generator: its reset output drives
//   this block's reset.
//   Feeds the FPGA TX pin for host debug and telemetry.
// PARAMETERS
//   CLK_HZ     12_000_000  input clock frequency, Hz
//   BAUD       115_200     line rate, bits/s
//   DATA_BITS  8           data bits per frame, 5..8
//   STOP_BITS  1           stop bits per frame, 1..2
//   DIV (localparam) = (CLK_HZ + BAUD/2) / BAUD, clocks per bit
//     - Defaults give 104.
//     - Elaboration error if DIV < 2.
// PORTS
//   clk    in   1          system clock, all logic on posedge
//   reset  in   1          synchronous, active-high
//   data   in   DATA_BITS  byte to send, sampled only on accept
//   valid  in   1          data valid from producer
//   ready  out  1          transmitter can accept data this cycle
//   tx     out  1          serial line, idles high, registered
//   busy   out  1          high while a frame is on the line
// BEHAVIOUR
//   Reset:
//     - While reset is sampled high: tx=1, ready=0, busy=0, state=IDLE,
//       counters cleared.
//     - First cycle after release: ready=1.
//   Handshake:
//     - Accept occurs on a posedge with valid && ready.
//     - data is latched into the shift register on that edge; later changes
//       to data are ignored.
//     - valid while ready=0 is ignored; the producer holds valid.
//   Latency: tx drops to 0 (start bit) on the edge after accept.
//   States:
//     - IDLE -> START on accept.
//     - START -> DATA after DIV cycles.
//     - DATA -> STOP after DATA_BITS*DIV cycles; bits are sent LSB first,
//       one bit per DIV cycles.
//     - STOP -> IDLE after STOP_BITS*DIV cycles, unless accept occurs in
//       the final STOP cycle.
//     - If accept occurs in the final STOP cycle: STOP -> START.
//   ready:
//     - 1 in IDLE.
//     - 1 in the last clock of the last stop bit.
//     - 0 otherwise.
//   Back-to-back: valid held continuously gives a frame period of exactly
//     (1+DATA_BITS+STOP_BITS)*DIV cycles, with no idle gap.
//   busy: 1 from the cycle tx enters START until the cycle state returns to
//     IDLE.
//   Bit timer:
//     - Width $clog2(DIV), down-counts DIV-1..0.
//     - Reloaded on accept so the start bit is exactly DIV cycles long.
//     - Wraps only through reload; the value is never compared past 0.
//   Bit index: width $clog2(DATA_BITS+1); it is never read outside DATA/STOP.
//   Reset mid-frame: the frame is aborted, tx=1 on the next edge, no resume;
//     the latched byte is discarded.
//   Reset and valid in the same cycle: reset wins, nothing is accepted.
// STRUCTURE
//   Shared include uart_defs.vh:
//     - state encodings (IDLE/START/DATA/STOP, 2 bits)
//     - DIV rounding expression, reused by a future uart_rx
//   Sub-module baud_tick (one natural split):
//     - Parameter DIV; inputs clk, reset, restart; output tick, one cycle
//       per DIV.
//     - restart reloads DIV-1.
//   Top level: FSM, shift register and handshake logic.
// TESTING (bench overrides CLK_HZ=8, BAUD=2 -> DIV=4 unless noted)
//   1. Reset held 5 cycles:
//      -> tx=1, ready=0, busy=0 throughout; ready=1 the first cycle after.
//   2. Send 0xA5:
//      -> tx = 0 | 1,0,1,0,0,1,0,1 | 1, each level held 4 cycles,
//         40 cycles total.
//      -> ready=1 on cycle 40.
//   3. valid held with 0x00 then 0xFF:
//      -> second start bit directly follows the first stop bit.
//      -> 80 cycles total, tx never idles between frames.
//   4. data changed to 0x3C two cycles after accepting 0x81:
//      -> line carries 0x81.
//   5. Reset pulse at cycle 15 of a frame:
//      -> tx=1 next cycle, busy=0.
//      -> next 0x55 frame after release is bit-exact.
//   6. Defaults with STOP_BITS=2 (DIV=104):
//      -> frame length 1144 cycles.
//      -> each bit holds exactly 104 cycles, checked by edge timestamps.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and the bit-period rounding
// helper, reused by the receiver.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-to-transmitter valid/ready handshake carrying one data word.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: pulses tick for one clock every DIV clocks; restart
// reloads the period so the next tick lands exactly DIV clocks later.
module baud_tick #(
  parameter int unsigned DIV = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(DIV - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - TW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, N data bits LSB first, no parity, 1..2 stop bits.
// Bit timing comes from an internal tick, not a derived clock.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  uart_tx_if.slave    up,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned IW  = $clog2(DATA_BITS + 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx: DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_data_check
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_tx: STOP_BITS must be 1..2");
  end

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        idx;
  logic                 idle_rdy;
  logic                 tick;
  logic                 last_stop;
  logic                 ready;
  logic                 accept;

  // idle_rdy is a register so ready stays low for the first cycle after
  // reset; the stop-bit term lets a new frame start with no idle gap.
  assign last_stop = (idx == IW'(STOP_BITS - 1));
  assign ready     = idle_rdy || (state == STOP && last_stop && tick);
  assign accept    = up.valid && ready && !reset;
  assign up.ready  = ready;

  baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      idle_rdy <= 1'b0;
      idx      <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_rdy <= 1'b1;
          if (accept) begin
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            shreg    <= up.data;
            idx      <= '0;
            idle_rdy <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            idx   <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == IW'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= 1'b1;
              idx   <= '0;
            end else begin
              tx    <= shreg[0];
              shreg <= shreg >> 1;
              idx   <= idx + IW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (!last_stop) begin
              idx <= idx + IW'(1);
            end else if (accept) begin
              state <= START;
              tx    <= 1'b0;
              shreg <= up.data;
              idx   <= '0;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              idle_rdy <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a DIV=4 instance for frame/handshake/reset
// cases and a default-rate 2-stop-bit instance for timestamped bit widths.
module tb_uart_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx1, busy1, tx2, busy2;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  uart_tx_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_if #(.DATA_BITS(8)) bus2 ();

  uart_tx #(.CLK_HZ(8), .BAUD(2), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .up(bus1), .tx(tx1), .busy(busy1)
  );

  uart_tx #(.CLK_HZ(12_000_000), .BAUD(115_200), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .up(bus2), .tx(tx2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level in cycle c (1-based after accept) for DIV=4, 8N1.
  function automatic logic exp_level(input logic [7:0] b, input int unsigned c);
    int unsigned k;
    k = (c - 1) / 4;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Entered at the negedge of cycle 1; returns at the negedge of cycle 40.
  task automatic check_frame(input logic [7:0] b, input int unsigned chg_cycle,
                             input logic [7:0] chg_data, input string tag);
    for (int unsigned c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("%s_tx_c%0d", tag, c), {31'd0, tx1}, {31'd0, exp_level(b, c)});
      chk($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy1}, 32'd1);
      chk($sformatf("%s_ready_c%0d", tag, c), {31'd0, bus1.ready}, (c == 40) ? 32'd1 : 32'd0);
      if (c == chg_cycle) bus1.data = chg_data;
    end
  endtask

  int unsigned edges[$];
  int unsigned exp_edges[8] = '{1, 105, 313, 417, 521, 729, 833, 937};
  int unsigned end_c;
  logic prev;

  initial begin
    bus1.data = 8'h00; bus1.valid = 1'b0;
    bus2.data = 8'h00; bus2.valid = 1'b0;

    // 1. reset held 5 cycles, valid asserted during reset must be ignored
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst_tx_%0d", i), {31'd0, tx1}, 32'd1);
      chk($sformatf("rst_ready_%0d", i), {31'd0, bus1.ready}, 32'd0);
      chk($sformatf("rst_busy_%0d", i), {31'd0, busy1}, 32'd0);
      if (i >= 3) bus1.valid = 1'b1;
    end
    bus1.valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", {31'd0, bus1.ready}, 32'd1);
    chk("rel_tx", {31'd0, tx1}, 32'd1);
    chk("rel_busy", {31'd0, busy1}, 32'd0);

    // 2. single frame 0xA5
    bus1.data = 8'hA5; bus1.valid = 1'b1;
    @(negedge clk);
    bus1.valid = 1'b0;
    check_frame(8'hA5, 0, 8'h00, "a5");
    @(negedge clk);
    chk("a5_idle_tx", {31'd0, tx1}, 32'd1);
    chk("a5_idle_busy", {31'd0, busy1}, 32'd0);
    chk("a5_idle_ready", {31'd0, bus1.ready}, 32'd1);

    // 3. back-to-back 0x00 then 0xFF with valid held
    bus1.data = 8'h00; bus1.valid = 1'b1;
    @(negedge clk);
    check_frame(8'h00, 1, 8'hFF, "b2b0");
    @(negedge clk);
    bus1.valid = 1'b0;
    check_frame(8'hFF, 0, 8'h00, "b2b1");
    @(negedge clk);
    chk("b2b_idle_tx", {31'd0, tx1}, 32'd1);
    chk("b2b_idle_busy", {31'd0, busy1}, 32'd0);

    // 4. data changes to 0x3C two cycles after accepting 0x81
    bus1.data = 8'h81; bus1.valid = 1'b1;
    @(negedge clk);
    bus1.valid = 1'b0;
    check_frame(8'h81, 2, 8'h3C, "hold");
    @(negedge clk);

    // 5. reset at cycle 15 of a 0xF0 frame, then a clean 0x55 frame
    bus1.data = 8'hF0; bus1.valid = 1'b1;
    @(negedge clk);
    bus1.valid = 1'b0;
    for (int unsigned c = 1; c <= 15; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("abort_tx_c%0d", c), {31'd0, tx1}, {31'd0, exp_level(8'hF0, c)});
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_tx", {31'd0, tx1}, 32'd1);
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_ready", {31'd0, bus1.ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rel_ready", {31'd0, bus1.ready}, 32'd1);
    chk("abort_rel_tx", {31'd0, tx1}, 32'd1);
    bus1.data = 8'h55; bus1.valid = 1'b1;
    @(negedge clk);
    bus1.valid = 1'b0;
    check_frame(8'h55, 0, 8'h00, "post");
    @(negedge clk);

    // 6. default rate, 2 stop bits: 0x4B framed over 1144 cycles
    chk("d2_ready_idle", {31'd0, bus2.ready}, 32'd1);
    bus2.data = 8'h4B; bus2.valid = 1'b1;
    @(negedge clk);
    bus2.valid = 1'b0;
    prev = 1'b1;
    end_c = 0;
    for (int unsigned c = 1; c <= 1300; c++) begin
      if (c > 1) @(negedge clk);
      if (tx2 !== prev) begin
        edges.push_back(c);
        prev = tx2;
      end
      if (c == 1144) chk("d2_ready_last", {31'd0, bus2.ready}, 32'd1);
      if (c == 1143) chk("d2_ready_early", {31'd0, bus2.ready}, 32'd0);
      if (busy2 === 1'b0) begin
        end_c = c;
        break;
      end
    end
    chk("d2_frame_end", end_c, 32'd1145);
    chk("d2_edge_count", edges.size(), 32'd8);
    for (int unsigned i = 0; i < 8; i++) begin
      chk($sformatf("d2_edge_%0d", i), (i < edges.size()) ? edges[i] : 32'd0, exp_edges[i]);
    end
    chk("d2_idle_tx", {31'd0, tx2}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
